// File: rtl/fifo_prefetch_ctrl.sv
// rtl/fifo_prefetch_ctrl.sv - credit-based burst read prefetcher feeding a write-side FIFO
module fifo_prefetch_ctrl #(
   parameter int ADDR_W     = 28,
   parameter int DATA_W     = 256,
   parameter int LEVEL_W    = 11,
   parameter int FIFO_WORDS = 1024,
   parameter int BURST_LEN  = 16,
   parameter int MAX_OUTST  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [23:0]       total_beats,
   output logic              rd_req,
   input  logic              rd_ready,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [6:0]        rd_len,
   input  logic              rd_dvalid,
   input  logic [DATA_W-1:0] rd_data,
   output logic              fifo_wr_en,
   output logic [DATA_W-1:0] fifo_wr_data,
   input  logic [LEVEL_W-1:0] fifo_level,
   input  logic              fifo_full,
   output logic              busy,
   output logic              done,
   output logic              ovf_err
);

   localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, FIN} state_t;

   state_t           state;
   logic [23:0]      req_remaining;
   logic [23:0]      wr_remaining;
   logic [2:0]       outst;
   logic [15:0]      inflight;
   logic [6:0]       lens [MAX_OUTST];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [6:0]       beat_cnt;

   logic [6:0]  len_next;
   logic [31:0] credit;
   logic        can_issue;
   logic        hs;
   logic        last_beat;
   logic        accept_beat;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Credit: FIFO occupancy plus everything already requested must leave room for the next burst.
   always_comb begin
      len_next    = (req_remaining < 24'(BURST_LEN)) ? req_remaining[6:0] : 7'(BURST_LEN);
      credit      = 32'(fifo_level) + 32'(inflight) + 32'(len_next);
      can_issue   = (32'(outst) < 32'(MAX_OUTST)) && (credit <= 32'(FIFO_WORDS));
      hs          = rd_req & rd_ready;
      last_beat   = fifo_wr_en && ((beat_cnt + 7'd1) == lens[head]);
      accept_beat = rd_dvalid && (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         rd_req        <= 1'b0;
         rd_addr       <= '0;
         rd_len        <= '0;
         fifo_wr_en    <= 1'b0;
         fifo_wr_data  <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         ovf_err       <= 1'b0;
         req_remaining <= '0;
         wr_remaining  <= '0;
         outst         <= '0;
         inflight      <= '0;
         head          <= '0;
         tail          <= '0;
         beat_cnt      <= '0;
         for (int i = 0; i < MAX_OUTST; i++) lens[i] <= '0;
      end else begin
         fifo_wr_en <= accept_beat;
         if (accept_beat) fifo_wr_data <= rd_data;
         if (accept_beat && fifo_full) ovf_err <= 1'b1;
         done <= 1'b0;

         outst    <= outst + {2'b0, hs} - {2'b0, last_beat};
         inflight <= inflight + (hs ? 16'(rd_len) : 16'd0) - {15'd0, fifo_wr_en};
         if (hs) begin
            lens[tail] <= rd_len;
            tail       <= ptr_inc(tail);
         end
         if (fifo_wr_en) begin
            wr_remaining <= wr_remaining - 24'd1;
            if (last_beat) begin
               beat_cnt <= '0;
               head     <= ptr_inc(head);
            end else begin
               beat_cnt <= beat_cnt + 7'd1;
            end
         end

         case (state)
            IDLE: if (start) begin
               rd_addr       <= base_addr;
               req_remaining <= total_beats;
               wr_remaining  <= total_beats;
               busy          <= 1'b1;
               if (total_beats == 24'd0) begin
                  state <= FIN;
                  done  <= 1'b1;
               end else begin
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (rd_req) begin
                  if (rd_ready) begin
                     rd_req        <= 1'b0;
                     rd_addr       <= rd_addr + ADDR_W'(rd_len);
                     req_remaining <= req_remaining - 24'(rd_len);
                     if (req_remaining == 24'(rd_len)) state <= DRAIN;
                  end
               end else if (can_issue) begin
                  rd_req <= 1'b1;
                  rd_len <= len_next;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: if (can_issue) state <= ISSUE;
            DRAIN: if (fifo_wr_en && wr_remaining == 24'd1) begin
               state <= FIN;
               done  <= 1'b1;
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_prefetch_ctrl.sv
// tb/tb_fifo_prefetch_ctrl.sv - directed self-checking bench for fifo_prefetch_ctrl
module tb_fifo_prefetch_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [27:0]  base_addr;
   logic [23:0]  total_beats;
   logic         rd_req;
   logic         rd_ready;
   logic [27:0]  rd_addr;
   logic [6:0]   rd_len;
   logic         rd_dvalid;
   logic [255:0] rd_data;
   logic         fifo_wr_en;
   logic [255:0] fifo_wr_data;
   logic [10:0]  fifo_level;
   logic         fifo_full;
   logic         busy;
   logic         done;
   logic         ovf_err;

   always #5 clk = ~clk;

   fifo_prefetch_ctrl #(.FIFO_WORDS(1008)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .total_beats(total_beats), .rd_req(rd_req), .rd_ready(rd_ready),
      .rd_addr(rd_addr), .rd_len(rd_len), .rd_dvalid(rd_dvalid), .rd_data(rd_data),
      .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_level(fifo_level),
      .fifo_full(fifo_full), .busy(busy), .done(done), .ovf_err(ovf_err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   int          cyc = 0, hs_n = 0, wr_n = 0, done_n = 0, wr_cyc = 0, done_cyc = 0, req_beats = 0;
   logic [31:0] last_data = '0;
   logic [27:0] hs_addr [64];
   logic [6:0]  hs_len  [64];

   always @(posedge clk) begin
      cyc++;
      if (rd_req && rd_ready) begin
         if (hs_n < 64) begin
            hs_addr[hs_n] = rd_addr;
            hs_len[hs_n]  = rd_len;
         end
         hs_n++;
         req_beats += int'(rd_len);
      end
      if (fifo_wr_en) begin
         wr_n++;
         wr_cyc    = cyc;
         last_data = fifo_wr_data[31:0];
      end
      if (done) begin
         done_n++;
         done_cyc = cyc;
      end
   end

   int beats_sent = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic full);
      rd_dvalid = 1'b1;
      rd_data   = {8{beats_sent[31:0]}};
      fifo_full = full;
      beats_sent++;
      tick();
      rd_dvalid = 1'b0;
      fifo_full = 1'b0;
   endtask

   task automatic pulse_start(input logic [27:0] addr, input logic [23:0] beats);
      base_addr   = addr;
      total_beats = beats;
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   task automatic run_to_done(input int budget, input string tag);
      int d0 = done_n;
      int k  = 0;
      while (done_n == d0 && k < budget) begin
         if (req_beats > beats_sent) send_beat(1'b0);
         else tick();
         k++;
      end
      check({tag, " done seen"}, 32'(done_n != d0), 32'd1);
   endtask

   int h0, w0;

   initial begin
      rst_n = 1'b0; start = 1'b0; base_addr = '0; total_beats = '0; rd_ready = 1'b0;
      rd_dvalid = 1'b0; rd_data = '0; fifo_level = '0; fifo_full = 1'b0;
      #13;
      check("reset outputs", {27'd0, rd_req, fifo_wr_en, busy, done, ovf_err}, 32'd0);
      check("reset rd_addr", 32'(rd_addr), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // basic 40-beat transfer
      h0 = hs_n; w0 = wr_n; rd_ready = 1'b1;
      pulse_start(28'h100, 24'd40);
      run_to_done(300, "basic");
      check("basic hs count", 32'(hs_n - h0), 32'd3);
      check("basic req0", {hs_addr[h0][23:0], 1'b0, hs_len[h0]}, {24'h100, 8'd16});
      check("basic req1", {hs_addr[h0+1][23:0], 1'b0, hs_len[h0+1]}, {24'h110, 8'd16});
      check("basic req2", {hs_addr[h0+2][23:0], 1'b0, hs_len[h0+2]}, {24'h120, 8'd8});
      check("basic writes", 32'(wr_n - w0), 32'd40);
      check("basic done latency", 32'(done_cyc - wr_cyc), 32'd1);
      check("basic last data", last_data, 32'(beats_sent - 1));
      check("basic idle after", {30'd0, busy, done}, 32'd0);

      // credit stall
      h0 = hs_n; w0 = wr_n; fifo_level = 11'd1000;
      pulse_start(28'h400, 24'd32);
      repeat (10) tick();
      check("credit stall hs", 32'(hs_n - h0), 32'd0);
      check("credit stall req/busy", {30'd0, rd_req, busy}, 32'd1);
      fifo_level = 11'd992;
      repeat (10) tick();
      check("credit one hs", 32'(hs_n - h0), 32'd1);
      check("credit req low", 32'(rd_req), 32'd0);
      fifo_level = 11'd0;
      run_to_done(300, "credit");
      check("credit hs total", 32'(hs_n - h0), 32'd2);
      check("credit writes", 32'(wr_n - w0), 32'd32);

      // outstanding limit with request held under back-pressure
      h0 = hs_n; w0 = wr_n; rd_ready = 1'b0;
      pulse_start(28'h200, 24'd64);
      repeat (3) tick();
      check("hold req", {rd_req, 3'd0, rd_addr, 1'b0, rd_len[2:0]} , {1'b1, 3'd0, 28'h200, 4'd0});
      check("hold len", 32'(rd_len), 32'd16);
      repeat (3) tick();
      check("hold stable", {rd_req, 3'd0, rd_addr}, {1'b1, 3'd0, 28'h200});
      rd_ready = 1'b1;
      repeat (20) tick();
      check("outst two hs", 32'(hs_n - h0), 32'd2);
      repeat (15) send_beat(1'b0);
      repeat (3) tick();
      check("outst blocked", {31'd0, rd_req}, 32'd0);
      check("outst still two", 32'(hs_n - h0), 32'd2);
      send_beat(1'b0);
      repeat (6) tick();
      check("outst third hs", 32'(hs_n - h0), 32'd3);
      check("outst third addr", 32'(hs_addr[h0+2]), 32'h220);
      run_to_done(400, "outst");
      check("outst hs total", 32'(hs_n - h0), 32'd4);
      check("outst writes", 32'(wr_n - w0), 32'd64);

      // zero-length transfer
      h0 = hs_n;
      pulse_start(28'h0, 24'd0);
      check("zero busy/done", {29'd0, busy, done, rd_req}, 32'b110);
      tick();
      check("zero back idle", {30'd0, busy, done}, 32'd0);
      check("zero no hs", 32'(hs_n - h0), 32'd0);

      // address wrap, write latency, overflow
      h0 = hs_n; w0 = wr_n;
      pulse_start(28'hFFFFFF8, 24'd16);
      repeat (4) tick();
      check("wrap hs", 32'(hs_n - h0), 32'd1);
      check("wrap req addr", 32'(hs_addr[h0]), 32'h0FFFFFF8);
      check("wrap req len", 32'(hs_len[h0]), 32'd16);
      check("wrap next addr", 32'(rd_addr), 32'd8);
      send_beat(1'b0);
      check("latency wr_en", 32'(fifo_wr_en), 32'd1);
      check("latency data", fifo_wr_data[31:0], 32'(beats_sent - 1));
      check("ovf clear", 32'(ovf_err), 32'd0);
      send_beat(1'b1);
      check("ovf set", 32'(ovf_err), 32'd1);
      run_to_done(200, "wrap");
      check("ovf sticky", 32'(ovf_err), 32'd1);
      check("wrap writes", 32'(wr_n - w0), 32'd16);

      // asynchronous reset in DRAIN
      h0 = hs_n;
      pulse_start(28'h0, 24'd32);
      repeat (8) tick();
      check("drain hs", 32'(hs_n - h0), 32'd2);
      repeat (5) send_beat(1'b0);
      rd_dvalid = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      check("async rst ctl", {27'd0, rd_req, fifo_wr_en, busy, done, ovf_err}, 32'd0);
      check("async rst addr/len", {rd_len[3:0], rd_addr}, 32'd0);
      check("async rst data", fifo_wr_data[31:0], 32'd0);
      w0 = wr_n;
      tick();
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      rd_dvalid = 1'b0;
      check("post rst no writes", 32'(wr_n - w0), 32'd0);
      check("post rst idle", {30'd0, busy, rd_req}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_prefetch_ctrl.md
FIFO_PREFETCH_CTRL -- requirements
Module: fifo_prefetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, beat-address width toward the memory controller.
REQ-002 SHALL have parameter DATA_W, default 256, beat data width, equal to the FIFO write width.
REQ-003 SHALL have parameter LEVEL_W, default 11, width of the FIFO write water level.
REQ-004 SHALL have parameter FIFO_WORDS, default 1024, FIFO write-side capacity in beats.
REQ-005 SHALL have parameter BURST_LEN, default 16, maximum beats per read request (1..64).
REQ-006 SHALL have parameter MAX_OUTST, default 2, maximum outstanding read requests (1..4).
REQ-007 Ports SHALL be, in order:
- clk  in  1  single clock; every output and internal register is in this domain.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle pulse that begins a transfer; ignored while busy=1.
- base_addr  in  ADDR_W  first beat address, sampled on accepted start.
- total_beats  in  24  beats to transfer, sampled on accepted start; 0 means done at once.
- rd_req  out  1  read request valid.
- rd_ready  in  1  memory controller accepts the request when rd_req=1 and rd_ready=1.
- rd_addr  out  ADDR_W  request beat address.
- rd_len  out  7  request length in beats (1..BURST_LEN).
- rd_dvalid  in  1  returned-data beat valid; cannot be back-pressured.
- rd_data  in  DATA_W  returned-data beat.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wr_data  out  DATA_W  FIFO write data.
- fifo_level  in  LEVEL_W  FIFO write water level.
- fifo_full  in  1  FIFO full flag.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when the last beat is written to the FIFO.
- ovf_err  out  1  sticky error: a beat arrived while fifo_full=1.

Function
REQ-008 FSM states SHALL be IDLE, ISSUE, WAIT, DRAIN, FIN.
REQ-009 IDLE SHALL move to ISSUE on start when total_beats>0; on start with total_beats=0 it SHALL move to FIN.
REQ-010 ISSUE SHALL assert rd_req only when both conditions hold:
- outstanding requests < MAX_OUTST;
- fifo_level + inflight_beats + len <= FIFO_WORDS, where inflight_beats = beats requested but not yet written.
REQ-011 If the ISSUE condition in REQ-010 fails, the FSM SHALL go to WAIT, deassert rd_req, and return to ISSUE on the first cycle the condition holds.
REQ-012 rd_len SHALL equal min(BURST_LEN, req_remaining); this comparison SHALL be at least 24 bits wide.
REQ-013 rd_addr, rd_len and rd_req SHALL stay stable from rd_req assertion until the rd_ready handshake.
REQ-014 On each handshake:
- rd_addr SHALL advance by rd_len, wrapping modulo 2^ADDR_W;
- req_remaining SHALL decrease by rd_len;
- the outstanding count SHALL increment.
REQ-015 When req_remaining reaches 0, ISSUE SHALL go to DRAIN.
REQ-016 Each rd_dvalid beat SHALL produce fifo_wr_en=1, with fifo_wr_data = rd_data, exactly one cycle later (registered, latency 1).
REQ-017 Outstanding-request accounting:
- the outstanding count SHALL decrement when a request's final beat is written;
- per-request lengths SHALL be held in a MAX_OUTST-deep length queue.
REQ-018 A handshake and a final-beat write in the same cycle SHALL leave the outstanding count unchanged.
REQ-019 inflight_beats SHALL update in one cycle as +rd_len on handshake and -1 on fifo_wr_en; both in the same cycle SHALL apply the net change.
REQ-020 DRAIN SHALL go to FIN when all total_beats have been written.
REQ-021 FIN SHALL pulse done for one cycle and return to IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 A beat with rd_dvalid=1 while fifo_full=1 SHALL:
- still pulse fifo_wr_en;
- set ovf_err, which clears only on reset;
- count as written.
REQ-024 rd_dvalid in IDLE SHALL be ignored and not written.

Reset
REQ-025 rst_n=0 SHALL asynchronously force:
- state IDLE;
- rd_req, fifo_wr_en, busy, done, ovf_err = 0;
- rd_addr, rd_len, fifo_wr_data, all counters and the length queue = 0.
REQ-026 Deassertion of rst_n SHALL take effect on the next rising clk edge.
REQ-027 Reset mid-transfer SHALL abandon all outstanding requests; beats returning afterwards SHALL be ignored per REQ-024.

Verification
REQ-028 Basic transfer: start, base_addr=0x100, total_beats=40, rd_ready=1, empty FIFO -> requests (0x100,16), (0x110,16), (0x120,8); 40 fifo_wr_en; done 1 cycle after the 40th beat.
REQ-029 Credit stall: fifo_level=1000, total_beats=32 -> rd_req stays 0; lower fifo_level to 1008-16=992 -> exactly one request issues.
REQ-030 Outstanding limit: MAX_OUTST=2, data withheld -> exactly two handshakes, then rd_req=0 until the first request's 16th beat is written.
REQ-031 Zero and wrap: total_beats=0 -> busy for 1 cycle, done pulse, no rd_req; base_addr=2^28-8, total_beats=16 -> requests at 2^28-8 (len 16) -> next address wraps to 8.
REQ-032 Faults: rd_dvalid with fifo_full=1 -> ovf_err=1 until reset; rst_n low mid-DRAIN -> all outputs 0 asynchronously, and later beats are not written.
